// File: rtl/pipelined_control_if.sv
// Interface between the ID stage and the pipeline control unit, plus the
// per-stage control bundle it returns to the datapath.
interface pipelined_control_if #(
   parameter int INSN_W  = 32,
   parameter int RADDR_W = 5
);
   // id_valid qualifies id_instr; while id_stall is high the front end must
   // hold PC and IF/ID so the same instruction is presented again next cycle.
   logic               id_valid;
   logic [INSN_W-1:0]  id_instr;
   logic               ex_redirect;
   logic               id_stall;
   logic               illegal_op;

   logic               ex_valid;
   logic               ex_alu_src;
   logic               ex_branch;
   logic               ex_jump;
   logic               ex_jumpr;
   logic [1:0]         ex_alu_op;
   logic               ex_mem_read;
   logic               ex_mem_write;
   logic               ex_mem_to_reg;
   logic               ex_reg_write;
   logic [RADDR_W-1:0] ex_rd;

   logic               mem_valid;
   logic               mem_mem_read;
   logic               mem_mem_write;
   logic               mem_mem_to_reg;
   logic               mem_reg_write;
   logic [RADDR_W-1:0] mem_rd;

   logic               wb_valid;
   logic               wb_mem_to_reg;
   logic               wb_reg_write;
   logic [RADDR_W-1:0] wb_rd;

   modport master (
      output id_valid, id_instr, ex_redirect,
      input  id_stall, illegal_op,
      input  ex_valid, ex_alu_src, ex_branch, ex_jump, ex_jumpr, ex_alu_op,
      input  ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_reg_write, ex_rd,
      input  mem_valid, mem_mem_read, mem_mem_write, mem_mem_to_reg,
      input  mem_reg_write, mem_rd,
      input  wb_valid, wb_mem_to_reg, wb_reg_write, wb_rd
   );

   modport slave (
      input  id_valid, id_instr, ex_redirect,
      output id_stall, illegal_op,
      output ex_valid, ex_alu_src, ex_branch, ex_jump, ex_jumpr, ex_alu_op,
      output ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_reg_write, ex_rd,
      output mem_valid, mem_mem_read, mem_mem_write, mem_mem_to_reg,
      output mem_reg_write, mem_rd,
      output wb_valid, wb_mem_to_reg, wb_reg_write, wb_rd
   );
endinterface

// File: rtl/pipelined_control.sv
// RISC-V 5-stage control unit: decodes ID, carries the control bundle through
// ID/EX, EX/MEM and MEM/WB, and inserts bubbles for load-use and redirects.
module pipelined_control #(
   parameter int INSN_W         = 32,
   parameter int RADDR_W        = 5,
   parameter bit HAZARD_EN      = 1'b1,
   parameter bit ILLEGAL_BUBBLE = 1'b1
) (
   input logic                clk,
   input logic                rst,
   pipelined_control_if.slave bus
);

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I_ALU  = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   typedef struct packed {
      logic               valid;
      logic               alu_src;
      logic               branch;
      logic               jump;
      logic               jumpr;
      logic [1:0]         alu_op;
      logic               mem_read;
      logic               mem_write;
      logic               mem_to_reg;
      logic               reg_write;
      logic [RADDR_W-1:0] rd;
   } ex_ctrl_t;

   typedef struct packed {
      logic               valid;
      logic               mem_read;
      logic               mem_write;
      logic               mem_to_reg;
      logic               reg_write;
      logic [RADDR_W-1:0] rd;
   } mem_ctrl_t;

   typedef struct packed {
      logic               valid;
      logic               mem_to_reg;
      logic               reg_write;
      logic [RADDR_W-1:0] rd;
   } wb_ctrl_t;

   logic [6:0]         opcode;
   logic [RADDR_W-1:0] rd_f;
   logic [RADDR_W-1:0] rs1_f;
   logic [RADDR_W-1:0] rs2_f;
   logic               unused_instr_bits;

   assign opcode            = bus.id_instr[6:0];
   assign rd_f              = bus.id_instr[11:7];
   assign rs1_f             = bus.id_instr[19:15];
   assign rs2_f             = bus.id_instr[24:20];
   assign unused_instr_bits = ^{bus.id_instr[INSN_W-1:25], bus.id_instr[14:12]};

   ex_ctrl_t  dec;
   logic      known_op;
   logic      use_rs1;
   logic      use_rs2;

   always_comb begin
      dec      = '0;
      known_op = 1'b1;
      use_rs1  = 1'b0;
      use_rs2  = 1'b0;
      case (opcode)
         OP_R: begin
            dec.reg_write = 1'b1;
            dec.alu_op    = 2'b10;
            use_rs1       = 1'b1;
            use_rs2       = 1'b1;
         end
         OP_I_ALU: begin
            dec.alu_src   = 1'b1;
            dec.reg_write = 1'b1;
            dec.alu_op    = 2'b11;
            use_rs1       = 1'b1;
         end
         OP_LOAD: begin
            dec.alu_src    = 1'b1;
            dec.mem_to_reg = 1'b1;
            dec.reg_write  = 1'b1;
            dec.mem_read   = 1'b1;
            use_rs1        = 1'b1;
         end
         OP_STORE: begin
            dec.alu_src   = 1'b1;
            dec.mem_write = 1'b1;
            use_rs1       = 1'b1;
            use_rs2       = 1'b1;
         end
         OP_BRANCH: begin
            dec.branch = 1'b1;
            dec.alu_op = 2'b01;
            use_rs1    = 1'b1;
            use_rs2    = 1'b1;
         end
         OP_JAL: begin
            dec.reg_write = 1'b1;
            dec.jump      = 1'b1;
         end
         OP_JALR: begin
            dec.alu_src   = 1'b1;
            dec.reg_write = 1'b1;
            dec.jumpr     = 1'b1;
            use_rs1       = 1'b1;
         end
         OP_LUI, OP_AUIPC: begin
            dec.alu_src   = 1'b1;
            dec.reg_write = 1'b1;
         end
         default: known_op = 1'b0;
      endcase
      // x0 is hard-wired: never write it, but keep rd for forwarding compares.
      if (rd_f == '0) dec.reg_write = 1'b0;
      dec.rd    = rd_f;
      dec.valid = 1'b1;
   end

   ex_ctrl_t  ex_q,  ex_d;
   mem_ctrl_t mem_q, mem_d;
   wb_ctrl_t  wb_q,  wb_d;
   logic      illegal_op_q, illegal_op_d;
   logic      load_use;
   logic      stall;

   // A load in EX cannot forward to the ID instruction until it reaches MEM.
   assign load_use = bus.id_valid & ex_q.valid & ex_q.mem_read & (ex_q.rd != '0) &
                     ((use_rs1 & (rs1_f == ex_q.rd)) | (use_rs2 & (rs2_f == ex_q.rd)));

   assign stall = HAZARD_EN & load_use & ~bus.ex_redirect & ~rst;

   always_comb begin
      ex_d         = '0;
      illegal_op_d = 1'b0;
      if (!rst && bus.id_valid && !bus.ex_redirect && !stall) begin
         if (known_op) begin
            ex_d = dec;
         end else begin
            illegal_op_d = 1'b1;
            ex_d.valid   = ~ILLEGAL_BUBBLE;
         end
      end
   end

   always_comb begin
      mem_d            = '0;
      mem_d.valid      = ex_q.valid;
      mem_d.mem_read   = ex_q.mem_read;
      mem_d.mem_write  = ex_q.mem_write;
      mem_d.mem_to_reg = ex_q.mem_to_reg;
      mem_d.reg_write  = ex_q.reg_write;
      mem_d.rd         = ex_q.rd;
   end

   always_comb begin
      wb_d            = '0;
      wb_d.valid      = mem_q.valid;
      wb_d.mem_to_reg = mem_q.mem_to_reg;
      wb_d.reg_write  = mem_q.reg_write;
      wb_d.rd         = mem_q.rd;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ex_q         <= '0;
         mem_q        <= '0;
         wb_q         <= '0;
         illegal_op_q <= 1'b0;
      end else begin
         ex_q         <= ex_d;
         mem_q        <= mem_d;
         wb_q         <= wb_d;
         illegal_op_q <= illegal_op_d;
      end
   end

   assign bus.id_stall       = stall;
   assign bus.illegal_op     = illegal_op_q;

   assign bus.ex_valid       = ex_q.valid;
   assign bus.ex_alu_src     = ex_q.alu_src;
   assign bus.ex_branch      = ex_q.branch;
   assign bus.ex_jump        = ex_q.jump;
   assign bus.ex_jumpr       = ex_q.jumpr;
   assign bus.ex_alu_op      = ex_q.alu_op;
   assign bus.ex_mem_read    = ex_q.mem_read;
   assign bus.ex_mem_write   = ex_q.mem_write;
   assign bus.ex_mem_to_reg  = ex_q.mem_to_reg;
   assign bus.ex_reg_write   = ex_q.reg_write;
   assign bus.ex_rd          = ex_q.rd;

   assign bus.mem_valid      = mem_q.valid;
   assign bus.mem_mem_read   = mem_q.mem_read;
   assign bus.mem_mem_write  = mem_q.mem_write;
   assign bus.mem_mem_to_reg = mem_q.mem_to_reg;
   assign bus.mem_reg_write  = mem_q.reg_write;
   assign bus.mem_rd         = mem_q.rd;

   assign bus.wb_valid       = wb_q.valid;
   assign bus.wb_mem_to_reg  = wb_q.mem_to_reg;
   assign bus.wb_reg_write   = wb_q.reg_write;
   assign bus.wb_rd          = wb_q.rd;

endmodule

// File: tb/tb_pipelined_control.sv
// Directed bench for pipelined_control: default build plus an
// ILLEGAL_BUBBLE=0 build driven with the same stimulus.
module tb_pipelined_control;

   localparam logic [31:0] I_ADD      = 32'h002081B3; // add  x3,x1,x2
   localparam logic [31:0] I_LW_X5    = 32'h0000A283; // lw   x5,0(x1)
   localparam logic [31:0] I_ADD_DEP  = 32'h00228333; // add  x6,x5,x2
   localparam logic [31:0] I_LW_X0    = 32'h0000A003; // lw   x0,0(x1)
   localparam logic [31:0] I_ADD_X0   = 32'h00200333; // add  x6,x0,x2
   localparam logic [31:0] I_BEQ      = 32'h00208063; // beq  x1,x2,0
   localparam logic [31:0] I_JAL_X1   = 32'h000000EF; // jal  x1,0
   localparam logic [31:0] I_ILLEGAL  = 32'h0000007F;

   logic clk;
   logic rst;
   int   n_tests;
   int   n_fail;

   pipelined_control_if #(.INSN_W(32), .RADDR_W(5)) bus ();
   pipelined_control_if #(.INSN_W(32), .RADDR_W(5)) bus_nb ();

   pipelined_control #(.INSN_W(32), .RADDR_W(5), .HAZARD_EN(1'b1), .ILLEGAL_BUBBLE(1'b1)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   pipelined_control #(.INSN_W(32), .RADDR_W(5), .HAZARD_EN(1'b1), .ILLEGAL_BUBBLE(1'b0)) dut_nb (
      .clk (clk),
      .rst (rst),
      .bus (bus_nb)
   );

   // {alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch, alu_op, jump, jumpr}
   logic [9:0] ex_bits;
   logic [9:0] ex_bits_nb;
   assign ex_bits    = {bus.ex_alu_src, bus.ex_mem_to_reg, bus.ex_reg_write, bus.ex_mem_read,
                        bus.ex_mem_write, bus.ex_branch, bus.ex_alu_op, bus.ex_jump, bus.ex_jumpr};
   assign ex_bits_nb = {bus_nb.ex_alu_src, bus_nb.ex_mem_to_reg, bus_nb.ex_reg_write,
                        bus_nb.ex_mem_read, bus_nb.ex_mem_write, bus_nb.ex_branch,
                        bus_nb.ex_alu_op, bus_nb.ex_jump, bus_nb.ex_jumpr};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic drive(input logic v, input logic [31:0] instr, input logic redir);
      bus.id_valid       = v;
      bus.id_instr       = instr;
      bus.ex_redirect    = redir;
      bus_nb.id_valid    = v;
      bus_nb.id_instr    = instr;
      bus_nb.ex_redirect = redir;
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic idle(input int n);
      drive(1'b0, 32'h0, 1'b0);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      drive(1'b1, I_ADD, 1'b0);
      tick();
      tick();
      n_tests++;
      if (bus.ex_valid !== 1'b0 || bus.mem_valid !== 1'b0 || bus.wb_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_valid: got %b%b%b expected 000", bus.ex_valid, bus.mem_valid, bus.wb_valid);
      end
      n_tests++;
      if (ex_bits !== 10'b0 || bus.ex_rd !== 5'd0) begin
         n_fail++;
         $display("FAIL reset_ex_ctrl: got %b rd %0d expected 0 rd 0", ex_bits, bus.ex_rd);
      end
      n_tests++;
      if (bus.illegal_op !== 1'b0 || bus.id_stall !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_flags: got illegal %b stall %b expected 0 0", bus.illegal_op, bus.id_stall);
      end
      rst = 1'b0;
      idle(1);
   endtask

   task automatic test_r_type();
      drive(1'b1, I_ADD, 1'b0);
      tick();
      n_tests++;
      if (bus.ex_valid !== 1'b1 || bus.ex_alu_op !== 2'b10 || bus.ex_reg_write !== 1'b1 || bus.ex_rd !== 5'd3) begin
         n_fail++;
         $display("FAIL r_ex: got v%b op%b rw%b rd%0d expected v1 op10 rw1 rd3",
                  bus.ex_valid, bus.ex_alu_op, bus.ex_reg_write, bus.ex_rd);
      end
      drive(1'b0, 32'h0, 1'b0);
      tick();
      n_tests++;
      if (bus.mem_reg_write !== 1'b1 || bus.mem_rd !== 5'd3 || bus.ex_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL r_mem: got rw%b rd%0d exv%b expected rw1 rd3 exv0",
                  bus.mem_reg_write, bus.mem_rd, bus.ex_valid);
      end
      tick();
      n_tests++;
      if (bus.wb_valid !== 1'b1 || bus.wb_reg_write !== 1'b1 || bus.wb_mem_to_reg !== 1'b0 || bus.wb_rd !== 5'd3) begin
         n_fail++;
         $display("FAIL r_wb: got v%b rw%b m2r%b rd%0d expected v1 rw1 m2r0 rd3",
                  bus.wb_valid, bus.wb_reg_write, bus.wb_mem_to_reg, bus.wb_rd);
      end
      idle(2);
   endtask

   task automatic test_decode_table();
      logic [31:0] instr [10];
      logic [9:0]  exp_bits [10];
      logic [4:0]  exp_rd [10];
      instr[0] = I_ADD;        exp_bits[0] = 10'b0010001000; exp_rd[0] = 5'd3;
      instr[1] = 32'h00508213; exp_bits[1] = 10'b1010001100; exp_rd[1] = 5'd4;
      instr[2] = I_LW_X5;      exp_bits[2] = 10'b1111000000; exp_rd[2] = 5'd5;
      instr[3] = 32'h0020A023; exp_bits[3] = 10'b1000100000; exp_rd[3] = 5'd0;
      instr[4] = I_BEQ;        exp_bits[4] = 10'b0000010100; exp_rd[4] = 5'd0;
      instr[5] = I_JAL_X1;     exp_bits[5] = 10'b0010000010; exp_rd[5] = 5'd1;
      instr[6] = 32'h000100E7; exp_bits[6] = 10'b1010000001; exp_rd[6] = 5'd1;
      instr[7] = 32'h000013B7; exp_bits[7] = 10'b1010000000; exp_rd[7] = 5'd7;
      instr[8] = 32'h00000417; exp_bits[8] = 10'b1010000000; exp_rd[8] = 5'd8;
      instr[9] = 32'h00208033; exp_bits[9] = 10'b0000001000; exp_rd[9] = 5'd0;
      for (int i = 0; i < 10; i++) begin
         drive(1'b1, instr[i], 1'b0);
         tick();
         n_tests++;
         if (bus.ex_valid !== 1'b1 || ex_bits !== exp_bits[i] || bus.ex_rd !== exp_rd[i]) begin
            n_fail++;
            $display("FAIL decode_%0d: got v%b ctrl %b rd %0d expected v1 ctrl %b rd %0d",
                     i, bus.ex_valid, ex_bits, bus.ex_rd, exp_bits[i], exp_rd[i]);
         end
      end
      idle(3);
   endtask

   task automatic test_load_use();
      drive(1'b1, I_LW_X5, 1'b0);
      tick();
      drive(1'b1, I_ADD_DEP, 1'b0);
      #1;
      n_tests++;
      if (bus.id_stall !== 1'b1) begin
         n_fail++;
         $display("FAIL lu_stall_on: got %b expected 1", bus.id_stall);
      end
      tick();
      n_tests++;
      if (bus.ex_valid !== 1'b0 || ex_bits !== 10'b0 || bus.mem_mem_read !== 1'b1 || bus.mem_rd !== 5'd5) begin
         n_fail++;
         $display("FAIL lu_bubble: got exv%b ctrl %b mrd%b mem_rd %0d expected exv0 ctrl 0 mrd1 mem_rd 5",
                  bus.ex_valid, ex_bits, bus.mem_mem_read, bus.mem_rd);
      end
      n_tests++;
      if (bus.id_stall !== 1'b0) begin
         n_fail++;
         $display("FAIL lu_stall_off: got %b expected 0", bus.id_stall);
      end
      tick();
      n_tests++;
      if (bus.ex_valid !== 1'b1 || bus.ex_rd !== 5'd6 || bus.wb_rd !== 5'd5 || bus.wb_mem_to_reg !== 1'b1) begin
         n_fail++;
         $display("FAIL lu_issue: got exv%b ex_rd %0d wb_rd %0d wb_m2r %b expected 1 6 5 1",
                  bus.ex_valid, bus.ex_rd, bus.wb_rd, bus.wb_mem_to_reg);
      end
      drive(1'b0, 32'h0, 1'b0);
      tick();
      tick();
      n_tests++;
      if (bus.wb_valid !== 1'b1 || bus.wb_rd !== 5'd6 || bus.wb_reg_write !== 1'b1) begin
         n_fail++;
         $display("FAIL lu_wb: got v%b rd %0d rw %b expected 1 6 1", bus.wb_valid, bus.wb_rd, bus.wb_reg_write);
      end
      idle(2);
   endtask

   task automatic test_load_x0();
      drive(1'b1, I_LW_X0, 1'b0);
      tick();
      n_tests++;
      if (bus.ex_valid !== 1'b1 || bus.ex_mem_read !== 1'b1 || bus.ex_reg_write !== 1'b0 || bus.ex_rd !== 5'd0) begin
         n_fail++;
         $display("FAIL lx0_ex: got v%b mrd%b rw%b rd %0d expected v1 mrd1 rw0 rd 0",
                  bus.ex_valid, bus.ex_mem_read, bus.ex_reg_write, bus.ex_rd);
      end
      drive(1'b1, I_ADD_X0, 1'b0);
      #1;
      n_tests++;
      if (bus.id_stall !== 1'b0) begin
         n_fail++;
         $display("FAIL lx0_stall: got %b expected 0", bus.id_stall);
      end
      tick();
      n_tests++;
      if (bus.ex_valid !== 1'b1 || bus.ex_rd !== 5'd6) begin
         n_fail++;
         $display("FAIL lx0_issue: got v%b rd %0d expected v1 rd 6", bus.ex_valid, bus.ex_rd);
      end
      idle(3);
   endtask

   task automatic test_redirect();
      drive(1'b1, I_BEQ, 1'b0);
      tick();
      n_tests++;
      if (bus.ex_branch !== 1'b1 || bus.ex_alu_op !== 2'b01 || bus.ex_reg_write !== 1'b0) begin
         n_fail++;
         $display("FAIL rd_beq: got br%b op%b rw%b expected br1 op01 rw0",
                  bus.ex_branch, bus.ex_alu_op, bus.ex_reg_write);
      end
      drive(1'b1, I_ADD_DEP, 1'b1);
      #1;
      n_tests++;
      if (bus.id_stall !== 1'b0) begin
         n_fail++;
         $display("FAIL rd_beq_stall: got %b expected 0", bus.id_stall);
      end
      tick();
      n_tests++;
      if (bus.ex_valid !== 1'b0 || ex_bits !== 10'b0 || bus.ex_rd !== 5'd0 || bus.mem_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL rd_beq_squash: got exv%b ctrl %b rd %0d memv%b expected 0 0 0 1",
                  bus.ex_valid, ex_bits, bus.ex_rd, bus.mem_valid);
      end
      idle(3);
      // load-use hazard present in ID at the same time as a redirect
      drive(1'b1, I_LW_X5, 1'b0);
      tick();
      drive(1'b1, I_ADD_DEP, 1'b1);
      #1;
      n_tests++;
      if (bus.id_stall !== 1'b0) begin
         n_fail++;
         $display("FAIL rd_lu_stall: got %b expected 0", bus.id_stall);
      end
      tick();
      n_tests++;
      if (bus.ex_valid !== 1'b0 || ex_bits !== 10'b0 || bus.ex_rd !== 5'd0) begin
         n_fail++;
         $display("FAIL rd_lu_squash: got exv%b ctrl %b rd %0d expected 0 0 0",
                  bus.ex_valid, ex_bits, bus.ex_rd);
      end
      idle(3);
   endtask

   task automatic test_illegal();
      drive(1'b1, I_ILLEGAL, 1'b0);
      tick();
      n_tests++;
      if (bus.illegal_op !== 1'b1 || bus.ex_valid !== 1'b0 || ex_bits !== 10'b0) begin
         n_fail++;
         $display("FAIL ill_bubble: got ill%b exv%b ctrl %b expected 1 0 0", bus.illegal_op, bus.ex_valid, ex_bits);
      end
      n_tests++;
      if (bus_nb.illegal_op !== 1'b1 || bus_nb.ex_valid !== 1'b1 || ex_bits_nb !== 10'b0) begin
         n_fail++;
         $display("FAIL ill_valid: got ill%b exv%b ctrl %b expected 1 1 0",
                  bus_nb.illegal_op, bus_nb.ex_valid, ex_bits_nb);
      end
      drive(1'b0, 32'h0, 1'b0);
      tick();
      n_tests++;
      if (bus.illegal_op !== 1'b0 || bus_nb.illegal_op !== 1'b0) begin
         n_fail++;
         $display("FAIL ill_pulse: got %b %b expected 0 0", bus.illegal_op, bus_nb.illegal_op);
      end
      drive(1'b1, I_ILLEGAL, 1'b1);
      tick();
      n_tests++;
      if (bus.illegal_op !== 1'b0 || bus_nb.illegal_op !== 1'b0 || bus_nb.ex_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL ill_squash: got ill%b ill_nb%b exv_nb%b expected 0 0 0",
                  bus.illegal_op, bus_nb.illegal_op, bus_nb.ex_valid);
      end
      idle(3);
   endtask

   task automatic test_reset_mid_stall();
      drive(1'b1, I_LW_X5, 1'b0);
      tick();
      drive(1'b1, I_ADD_DEP, 1'b0);
      #1;
      n_tests++;
      if (bus.id_stall !== 1'b1) begin
         n_fail++;
         $display("FAIL rms_pre_stall: got %b expected 1", bus.id_stall);
      end
      rst = 1'b1;
      #1;
      n_tests++;
      if (bus.id_stall !== 1'b0) begin
         n_fail++;
         $display("FAIL rms_stall_in_rst: got %b expected 0", bus.id_stall);
      end
      tick();
      n_tests++;
      if (bus.ex_valid !== 1'b0 || bus.mem_valid !== 1'b0 || bus.wb_valid !== 1'b0 ||
          bus.mem_mem_read !== 1'b0 || bus.mem_rd !== 5'd0 || bus.illegal_op !== 1'b0) begin
         n_fail++;
         $display("FAIL rms_cleared: got v%b%b%b mrd%b mem_rd %0d ill%b expected all 0",
                  bus.ex_valid, bus.mem_valid, bus.wb_valid, bus.mem_mem_read, bus.mem_rd, bus.illegal_op);
      end
      rst = 1'b0;
      drive(1'b1, I_JAL_X1, 1'b0);
      #1;
      n_tests++;
      if (bus.id_stall !== 1'b0) begin
         n_fail++;
         $display("FAIL rms_jal_stall: got %b expected 0", bus.id_stall);
      end
      tick();
      n_tests++;
      if (bus.ex_valid !== 1'b1 || bus.ex_jump !== 1'b1 || bus.ex_reg_write !== 1'b1 || bus.ex_rd !== 5'd1) begin
         n_fail++;
         $display("FAIL rms_jal: got v%b j%b rw%b rd %0d expected v1 j1 rw1 rd 1",
                  bus.ex_valid, bus.ex_jump, bus.ex_reg_write, bus.ex_rd);
      end
      idle(3);
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      rst     = 1'b1;
      drive(1'b0, 32'h0, 1'b0);
      test_reset();
      test_r_type();
      test_decode_table();
      test_load_use();
      test_load_x0();
      test_redirect();
      test_illegal();
      test_reset_mid_stall();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
